// File: rtl/game_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_mode_ctrl_if
//   Groups the screen-sequencer signals between the console top level and
//   game_mode_ctrl.
//
//   Handshake: there is no valid/ready pairing on this bus. Every input is a
//   level (or, for key_pulse, a one-cycle code) sampled on each rising clk
//   edge; every output is valid on every cycle. A consumer never stalls the
//   sequencer.
//
//   Inputs to the sequencer : x, y, key, key_pulse, menu_game, menu_rgb,
//                             sdoku_rgb, bb_rgb, sdoku_done, bb_done
//   Outputs of the sequencer: rgb, mode, menu_rst, sdoku_rst, bb_rst,
//                             sdoku_en, bb_en, state_dbg (FSM state, debug)
// -----------------------------------------------------------------------------
interface game_mode_ctrl_if;
  logic [9:0] x;
  logic [9:0] y;
  logic [4:0] key;
  logic [4:0] key_pulse;
  logic [1:0] menu_game;
  logic [2:0] menu_rgb;
  logic [2:0] sdoku_rgb;
  logic [2:0] bb_rgb;
  logic       sdoku_done;
  logic       bb_done;

  logic [2:0] rgb;
  logic [1:0] mode;
  logic       menu_rst;
  logic       sdoku_rst;
  logic       bb_rst;
  logic       sdoku_en;
  logic       bb_en;
  logic [2:0] state_dbg;

  // Driver side (console top level / testbench).
  modport master (
    output x, y, key, key_pulse, menu_game, menu_rgb, sdoku_rgb, bb_rgb,
           sdoku_done, bb_done,
    input  rgb, mode, menu_rst, sdoku_rst, bb_rst, sdoku_en, bb_en, state_dbg
  );

  // Sequencer side.
  modport slave (
    input  x, y, key, key_pulse, menu_game, menu_rgb, sdoku_rgb, bb_rgb,
           sdoku_done, bb_done,
    output rgb, mode, menu_rst, sdoku_rst, bb_rst, sdoku_en, bb_en, state_dbg
  );
endinterface

// File: rtl/game_mode_ctrl.sv
// -----------------------------------------------------------------------------
// game_mode_ctrl
//   Screen/game sequencer for the VGA console. Takes the menu's game-select
//   code, waits for a frame boundary, holds the chosen game in reset for
//   RST_CYCLES, runs it, and returns to the menu on game-over (after the
//   player confirms with SEL_KEY) or on an ESC_KEY held for HOLD_CYCLES.
//   Every screen switch lands on a frame boundary (x==0, y==0).
//
//   Ports:
//     clk  - pixel clock, only clock
//     rst  - synchronous active-high reset
//     bus  - game_mode_ctrl_if.slave (pixel position, keys, menu select,
//            game colours and done levels in; rgb, mode, per-screen
//            resets/enables and debug state out)
// -----------------------------------------------------------------------------
module game_mode_ctrl #(
  parameter logic [4:0]  SEL_KEY     = 5'h1d,
  parameter logic [4:0]  ESC_KEY     = 5'h1c,
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned RST_CYCLES  = 16
) (
  input logic             clk,
  input logic             rst,
  game_mode_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_MENU    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_LOAD    = 3'd2,
    S_RUN     = 3'd3,
    S_OVER    = 3'd4,
    S_EXIT    = 3'd5
  } state_t;

  localparam logic [24:0] HOLD_MAX  = 25'(HOLD_CYCLES);
  localparam logic [4:0]  LOAD_LAST = 5'(RST_CYCLES - 1);

  state_t      state_q, state_d;
  logic        tgt_q, tgt_d;        // 0 = Sudoku, 1 = Bubble Bobble
  logic [24:0] hold_q, hold_d;
  logic [24:0] hold_next;
  logic [4:0]  load_q, load_d;

  logic [1:0]  mode_q, mode_d;
  logic        menu_rst_q, menu_rst_d;
  logic        sdoku_rst_q, sdoku_rst_d;
  logic        bb_rst_q, bb_rst_d;
  logic        sdoku_en_q, sdoku_en_d;
  logic        bb_en_q, bb_en_d;

  logic        frame_start;
  logic        tgt_done;
  logic        game_on;

  assign frame_start = (bus.x == 10'd0) && (bus.y == 10'd0);
  assign tgt_done    = tgt_q ? bus.bb_done : bus.sdoku_done;

  // ESC hold count as it would be after this cycle; saturates.
  always_comb begin
    hold_next = '0;
    if (bus.key == ESC_KEY) begin
      hold_next = (hold_q == HOLD_MAX) ? hold_q : hold_q + 25'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    load_d  = load_q;
    case (state_q)
      S_MENU: begin
        if (bus.menu_game == 2'b00) begin
          tgt_d   = 1'b0;
          state_d = S_WAIT_IN;
        end else if (bus.menu_game == 2'b01) begin
          tgt_d   = 1'b1;
          state_d = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        if (frame_start) begin
          state_d = S_LOAD;
          load_d  = '0;
        end
      end
      S_LOAD: begin
        if (load_q == LOAD_LAST) begin
          state_d = S_RUN;
          hold_d  = '0;
        end else begin
          load_d = load_q + 5'd1;
        end
      end
      S_RUN: begin
        hold_d = hold_next;
        // Game-over takes priority over a simultaneous hold expiry.
        if (tgt_done) begin
          state_d = S_OVER;
        end else if (hold_next == HOLD_MAX) begin
          state_d = S_EXIT;
        end
      end
      S_OVER: begin
        if (bus.key_pulse == SEL_KEY) begin
          state_d = S_EXIT;
        end
      end
      S_EXIT: begin
        if (frame_start) begin
          state_d = S_MENU;
        end
      end
      default: state_d = S_MENU;
    endcase
  end

  // Output decode of the next state, so outputs change on the same edge
  // as the state register.
  always_comb begin
    game_on     = (state_d == S_LOAD) || (state_d == S_RUN) ||
                  (state_d == S_OVER) || (state_d == S_EXIT);
    mode_d      = game_on ? {1'b0, tgt_d} : 2'b11;
    menu_rst_d  = (state_d == S_EXIT);
    sdoku_rst_d = (state_d == S_LOAD) && !tgt_d;
    bb_rst_d    = (state_d == S_LOAD) &&  tgt_d;
    sdoku_en_d  = (state_d == S_RUN)  && !tgt_d;
    bb_en_d     = (state_d == S_RUN)  &&  tgt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_MENU;
      tgt_q       <= 1'b0;
      hold_q      <= '0;
      load_q      <= '0;
      mode_q      <= 2'b11;
      menu_rst_q  <= 1'b0;
      sdoku_rst_q <= 1'b0;
      bb_rst_q    <= 1'b0;
      sdoku_en_q  <= 1'b0;
      bb_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      hold_q      <= hold_d;
      load_q      <= load_d;
      mode_q      <= mode_d;
      menu_rst_q  <= menu_rst_d;
      sdoku_rst_q <= sdoku_rst_d;
      bb_rst_q    <= bb_rst_d;
      sdoku_en_q  <= sdoku_en_d;
      bb_en_q     <= bb_en_d;
    end
  end

  // Black during LOAD hides the game's half-initialised frame.
  always_comb begin
    if (state_q == S_LOAD) begin
      bus.rgb = 3'b000;
    end else begin
      case (mode_q)
        2'b00:   bus.rgb = bus.sdoku_rgb;
        2'b01:   bus.rgb = bus.bb_rgb;
        default: bus.rgb = bus.menu_rgb;
      endcase
    end
  end

  assign bus.mode      = mode_q;
  assign bus.menu_rst  = menu_rst_q;
  assign bus.sdoku_rst = sdoku_rst_q;
  assign bus.bb_rst    = bb_rst_q;
  assign bus.sdoku_en  = sdoku_en_q;
  assign bus.bb_en     = bb_en_q;
  assign bus.state_dbg = state_q;

endmodule
